// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, start + D_W data bits (LSB first) [+ parity] + stop.
// Latency: 2-clk input sync; word/strobes appear 1 clk after the mid-stop-bit sample.
// Backpressure: none; ff_full at the stop decision drops the word and pulses rx_overrun.
// Optional parity state and par_err output are built when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps

module uart_rx #(
  parameter int D_W    = 8,
  parameter int B_TICK = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PAR_ODD = 1'b0
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           baud_clk,
  input  logic           rx,
  output logic           baud_en,
  output logic [D_W-1:0] rx_data,
  output logic           rx_done,
  output logic           frame_err,
  output logic           rx_overrun,
  output logic           ff_wr_en,
  output logic [D_W-1:0] ff_wr_data,
  input  logic           ff_full
`ifdef UART_RX_PARITY_EN
  , output logic         par_err
`endif
);

  localparam int TW = $clog2(B_TICK);
  localparam int CW = $clog2(D_W + 1);

  localparam logic [TW-1:0] T_HALF   = TW'(B_TICK / 2 - 1);
  localparam logic [TW-1:0] T_FULL   = TW'(B_TICK - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(D_W - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic           rx_m;
  logic           rx_s;
  logic           rx_q;
  logic [2:0]     state;
  logic [TW-1:0]  t_counter;
  logic [CW-1:0]  bit_cnt;
  logic [D_W-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic           par_bit;
`endif

  // Two-flop synchronizer for the async pin plus one delay flop for edge detection; idle-high reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  // Frame FSM: mid-bit sampling driven by baud ticks, with registered one-clk result strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      t_counter  <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      ff_wr_data <= '0;
      baud_en    <= 1'b0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
      ff_wr_en   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      par_err    <= 1'b0;
`endif
    end else begin
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
      ff_wr_en   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Only a genuine 1->0 transition starts a frame; a line stuck low is ignored.
          if (rx_q && !rx_s) begin
            state     <= START;
            t_counter <= '0;
            baud_en   <= 1'b1;
          end
        end

        START: begin
          if (baud_clk) begin
            if (t_counter == T_HALF) begin
              t_counter <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                // Line went back high before mid-start: treat as noise.
                state   <= IDLE;
                baud_en <= 1'b0;
              end
            end else begin
              t_counter <= t_counter + 1'b1;
            end
          end
        end

        DATA: begin
          if (baud_clk) begin
            if (t_counter == T_FULL) begin
              shreg     <= {rx_s, shreg[D_W-1:1]};
              t_counter <= '0;
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              t_counter <= t_counter + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_clk) begin
            if (t_counter == T_FULL) begin
              par_bit   <= rx_s;
              t_counter <= '0;
              state     <= STOP;
            end else begin
              t_counter <= t_counter + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (baud_clk) begin
            if (t_counter == T_FULL) begin
              state     <= IDLE;
              baud_en   <= 1'b0;
              t_counter <= '0;
              if (!rx_s) begin
                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if ((^shreg ^ par_bit) != PAR_ODD) begin
                par_err <= 1'b1;
`endif
              end else begin
                rx_data <= shreg;
                rx_done <= 1'b1;
                if (ff_full) begin
                  rx_overrun <= 1'b1;
                end else begin
                  ff_wr_en   <= 1'b1;
                  ff_wr_data <= shreg;
                end
              end
            end else begin
              t_counter <= t_counter + 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          baud_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames bit by bit and scores every result strobe against a queue
// of expected events computed from the frame contents, stop level, parity and ff_full.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int D_W      = 8;
  localparam int B_TICK   = 16;
  localparam int BAUD_DIV = 4;
  localparam int BIT_CLKS = B_TICK * BAUD_DIV;
  localparam bit PAR_ODD  = 1'b0;

  // Expected event flags: {ff_wr_en, rx_done, frame_err, rx_overrun, par_err}
  localparam logic [4:0] EV_WR   = 5'b11000;
  localparam logic [4:0] EV_OVR  = 5'b01010;
  localparam logic [4:0] EV_FERR = 5'b00100;
  localparam logic [4:0] EV_PERR = 5'b00001;

  typedef struct packed {
    logic [4:0]     flags;
    logic [D_W-1:0] wdat;
    logic [D_W-1:0] rxd;
  } ev_t;

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b0;
  logic           baud_clk = 1'b0;
  logic           rx       = 1'b1;
  logic           ff_full  = 1'b0;
  logic           baud_en;
  logic [D_W-1:0] rx_data;
  logic           rx_done;
  logic           frame_err;
  logic           rx_overrun;
  logic           ff_wr_en;
  logic [D_W-1:0] ff_wr_data;
  logic           par_err_w;

  int checks = 0;
  int errors = 0;
  int bdiv   = 0;

  ev_t            exp_q[$];
  logic [D_W-1:0] last_good = '0;

  uart_rx #(.D_W(D_W), .B_TICK(B_TICK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_clk   (baud_clk),
    .rx         (rx),
    .baud_en    (baud_en),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .rx_overrun (rx_overrun),
    .ff_wr_en   (ff_wr_en),
    .ff_wr_data (ff_wr_data),
    .ff_full    (ff_full)
`ifdef UART_RX_PARITY_EN
    , .par_err  (par_err_w)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign par_err_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // Free-running baud tick: one clk high every BAUD_DIV clks, changed away from the active edge.
  always @(negedge clk) begin
    bdiv     = (bdiv == BAUD_DIV - 1) ? 0 : bdiv + 1;
    baud_clk = (bdiv == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle showing any strobe must match the next expected event.
  always @(negedge clk) begin
    logic [4:0] act;
    ev_t        e;
    act = {ff_wr_en, rx_done, frame_err, rx_overrun, par_err_w};
    if (rst_n && act != 5'b0) begin
      if (exp_q.size() == 0) begin
        check("spurious_event", {27'b0, act}, 32'b0);
      end else begin
        e = exp_q.pop_front();
        check("event_flags", {27'b0, act}, {27'b0, e.flags});
        check("rx_data", {24'b0, rx_data}, {24'b0, e.rxd});
        if (e.flags[4]) check("ff_wr_data", {24'b0, ff_wr_data}, {24'b0, e.wdat});
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Reference model: the outcome of a frame follows directly from stop level, parity and ff_full.
  task automatic send_frame(input logic [D_W-1:0] d, input logic stop, input logic full,
                            input logic bad_par);
    ev_t  e;
    logic pbit;
    ff_full = full;
    pbit    = (^d) ^ PAR_ODD ^ bad_par;
    e.wdat  = d;
    if (!stop) begin
      e.flags = EV_FERR;
      e.rxd   = last_good;
`ifdef UART_RX_PARITY_EN
    end else if (bad_par) begin
      e.flags = EV_PERR;
      e.rxd   = last_good;
`endif
    end else begin
      last_good = d;
      e.flags   = full ? EV_OVR : EV_WR;
      e.rxd     = d;
    end
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < D_W; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit);
`endif
    send_bit(stop);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_rx_data"}, {24'b0, rx_data}, 32'b0);
    check({name, "_ff_wr_data"}, {24'b0, ff_wr_data}, 32'b0);
    check({name, "_baud_en"}, {31'b0, baud_en}, 32'b0);
    check({name, "_strobes"}, {27'b0, ff_wr_en, rx_done, frame_err, rx_overrun, par_err_w}, 32'b0);
  endtask

  initial begin
    logic [D_W-1:0] d;
    logic           full;
    logic           stop;
    logic           bp;
    logic [D_W-1:0] rst_word;

    // Reset state
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    send_bit(1'b1);

    // 1. Good frame
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("baud_en_after_frame", {31'b0, baud_en}, 32'b0);
    send_bit(1'b1);

    // 2. Framing error, then held-low line, then a good frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3) send_bit(1'b0);
    send_bit(1'b1);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1);

    // 3. Glitch of 3 baud ticks
    rx = 1'b0;
    repeat (3 * BAUD_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("baud_en_after_glitch", {31'b0, baud_en}, 32'b0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1);

    // 4. Overrun
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1);

    // 5. Back-to-back frames
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1);

    // 6. Reset during data bit 4 of 0x96
    rst_word = 8'h96;
    ff_full  = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rst_word[i]);
    rx = rst_word[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("baud_en_mid_frame", {31'b0, baud_en}, 32'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_quiet("midframe_reset");
    last_good = '0;
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h42, 1'b1, 1'b0, 1'b1);
    send_bit(1'b1);
`endif

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      d    = D_W'($urandom);
      full = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      bp   = ($urandom_range(0, 4) == 0);
`else
      bp   = 1'b0;
`endif
      send_frame(d, stop, full, bp);
      if (!stop) send_bit(1'b1);
      else repeat ($urandom_range(0, 2)) send_bit(1'b1);
    end

    ff_full = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("pending_events", exp_q.size(), 32'b0);
    check("baud_en_end", {31'b0, baud_en}, 32'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive side of the team UART; the counterpart to uart_tx.
- Oversamples the serial line using the shared baud generator tick (B_TICK ticks per bit).
- Frames start/data/stop bits LSB-first, flags framing and overrun errors, and pushes each good byte into the RX FIFO through a write-enable interface.
- Sits between the pad-side rx pin and the RX FIFO/controller.

Parameters:
- D_W, 8, data bits per frame (5..9).
- B_TICK, 16, baud ticks per bit period (even, >=8).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- baud_clk  input  1  baud generator tick; one-clk-wide pulse, B_TICK per bit.
- rx  input  1  asynchronous serial line; idle high.
- baud_en  output  1  baud generator enable; high while a frame is in progress.
- rx_data  output  D_W  last received word; held until the next good frame.
- rx_done  output  1  one-clk pulse on a good frame.
- frame_err  output  1  one-clk pulse when the stop bit samples 0.
- rx_overrun  output  1  one-clk pulse when a good frame is dropped because the FIFO is full.
- ff_wr_en  output  1  one-clk FIFO write strobe.
- ff_wr_data  output  D_W  FIFO write data; valid while ff_wr_en is high.
- ff_full  input  1  FIFO full flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; counters and shift register are cleared.
  - rx_data=0, ff_wr_data=0, baud_en=0, rx_done=0, frame_err=0, rx_overrun=0, ff_wr_en=0.
  - Synchronizer flops are set to 1.
  - A reset during a frame aborts it with no write and no flag.
- Input sync: rx passes through 2 flops (rx_s); edge detect uses a third flop (rx_q). Latency from pin to rx_s is 2 clk.
- t_counter is $clog2(B_TICK) bits wide and advances only on cycles where baud_clk=1. bit_cnt is $clog2(D_W+1) bits wide.
- IDLE:
  - baud_en=0.
  - A falling edge (rx_q=1, rx_s=0) moves to START, sets t_counter=0 and baud_en=1.
  - A line held low does not retrigger; a new 1->0 edge is required.
- START:
  - On a tick with t_counter==B_TICK/2-1, sample rx_s.
  - rx_s=0: go to DATA with t_counter=0, bit_cnt=0.
  - rx_s=1 (glitch): return to IDLE with no flag.
- DATA:
  - On a tick with t_counter==B_TICK-1, shift rx_s into the MSB of the shift register (LSB-first reception), set t_counter=0 and increment bit_cnt.
  - When the shifted bit is number D_W, go to STOP.
- STOP:
  - On a tick with t_counter==B_TICK-1, sample rx_s and return to IDLE.
  - rx_s=1 and ff_full=0: in the next clk, rx_data and ff_wr_data take the word, and ff_wr_en and rx_done pulse together.
  - rx_s=1 and ff_full=1: rx_data still updates and rx_done pulses; ff_wr_en stays 0 and rx_overrun pulses.
  - rx_s=0: frame_err pulses; no write; rx_data is unchanged.
- Sampling points are mid-bit: half a bit after the start edge, then every B_TICK ticks.
- All pulse outputs last exactly 1 clk.
- ff_full is sampled only in the stop-decision cycle.
- baud_clk ticks in IDLE are ignored.
- A new start edge is accepted the clk after the return to IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, with bit timing identical to a data bit.
  - Parameter PAR_ODD (default 0) selects odd parity when set, even parity otherwise.
  - New output par_err (1 bit, reset 0) pulses in the stop-decision cycle if the sampled parity bit mismatches.
  - A parity-error frame is not written to the FIFO and does not pulse rx_done; rx_data is unchanged.
  - frame_err has priority: if both errors occur, only frame_err pulses.
- Undefined:
  - No PARITY state, no par_err port, no PAR_ODD parameter.
  - A frame is start + D_W + stop.

Test Plan:
1. Good frame: B_TICK=16, baud_clk every 4 clk, send 0xA5 (8N1), ff_full=0 -> exactly one ff_wr_en pulse with ff_wr_data=0xA5; rx_done pulses in the same cycle; rx_data=0xA5; baud_en low after the frame.
2. Framing error: send 0x3C with the stop bit driven 0 -> frame_err pulse; ff_wr_en never asserts; rx_data keeps its prior value. Hold the line low for 3 bit times then raise it and send 0x01 -> 0x01 is written once, with no spurious frame from the held-low period.
3. Glitch rejection: 0-pulse of 3 baud ticks on an idle line -> return to IDLE, no outputs. A following 0x7E is received correctly.
4. Overrun: ff_full=1 throughout, send 0x55 -> rx_done and rx_overrun pulse; no ff_wr_en; rx_data=0x55.
5. Back-to-back frames: 0x00, 0xFF, 0x81 with no idle gap between stop and next start -> three writes in order with those values.
6. Reset mid-frame: assert rst_n=0 for 1 clk during data bit 4 of 0x96 -> all outputs 0, no write. The next frame 0x42 is received correctly. With UART_RX_PARITY_EN defined and PAR_ODD=0, 0x42 sent with parity bit 1 -> par_err pulse and no write.
